// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-response receiver: FSM state encoding,
// CRC7 polynomial, frame lengths and the bit-serial CRC7 update.
package sd_pkg;

  typedef logic [1:0] sd_state_t;

  localparam sd_state_t ST_IDLE       = 2'd0;
  localparam sd_state_t ST_WAIT_START = 2'd1;
  localparam sd_state_t ST_RECV       = 2'd2;
  localparam sd_state_t ST_DONE       = 2'd3;

  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1, x^7 term implicit

  localparam int unsigned FRAME_SHORT = 48;
  localparam int unsigned FRAME_LONG  = 136;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_sync.sv
// Bit-serial CRC7 LFSR, initial value 0, synchronously cleared when a reception is armed.
module sd_crc7_sync
  import sd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_r;

  // CRC shift register: clear has priority over accumulate
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_r <= 7'd0;
    end else if (clr_i) begin
      crc_r <= 7'd0;
    end else if (en_i) begin
      crc_r <= crc7_next(crc_r, bit_i);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc_o = crc_r;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver (48-bit short / 136-bit R2 long frames).
// CRC checking is built only when SD_RESP_CRC_CHK_EN is defined; otherwise crc_err_o is 0.
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         sd_strb_i,
  input  logic         cmd_i,
  input  logic         start_i,
  input  logic         long_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [119:0] resp_o,
  output logic         crc_err_o,
  output logic         end_err_o,
  output logic         tx_err_o,
  output logic         timeout_o
);

  // One counter serves both the Ncr strobe count and the received-bit count
  localparam int CW = ($clog2(NCR_MAX) > 8) ? $clog2(NCR_MAX) : 8;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TMO  = CW'(NCR_MAX - 1);
  localparam logic [CW-1:0] SH_LAST  = CW'(FRAME_SHORT - 1);
  localparam logic [CW-1:0] LG_LAST  = CW'(FRAME_LONG - 1);
  localparam logic [CW-1:0] SH_PL_LO = CW'(2);
  localparam logic [CW-1:0] SH_PL_HI = CW'(FRAME_SHORT - 9);
  localparam logic [CW-1:0] LG_PL_LO = CW'(8);
  localparam logic [CW-1:0] LG_PL_HI = CW'(FRAME_LONG - 9);

  sd_state_t     state_r;
  sd_state_t     state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          long_r;
  logic          busy_r;
  logic          done_r;
  logic [119:0]  resp_r;
  logic          tx_err_r;
  logic          end_err_r;
  logic          timeout_r;

  logic          accept_s;
  logic          wait_strb_s;
  logic          start_bit_s;
  logic          tmo_s;
  logic          rx_bit_s;
  logic          last_bit_s;
  logic          payload_s;
  logic [CW-1:0] last_cnt_s;

  // Event decode and next-state selection; abort overrides every state
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && start_i && !abort_i;
    wait_strb_s = (state_r == ST_WAIT_START) && sd_strb_i && !abort_i;
    start_bit_s = wait_strb_s && !cmd_i;
    tmo_s       = wait_strb_s && cmd_i && (cnt_r == CNT_TMO);
    rx_bit_s    = (state_r == ST_RECV) && sd_strb_i && !abort_i;
    last_cnt_s  = long_r ? LG_LAST : SH_LAST;
    last_bit_s  = rx_bit_s && (cnt_r == last_cnt_s);
    if (long_r) begin
      payload_s = (cnt_r >= LG_PL_LO) && (cnt_r <= LG_PL_HI);
    end else begin
      payload_s = (cnt_r >= SH_PL_LO) && (cnt_r <= SH_PL_HI);
    end

    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_WAIT_START;
        else          state_nxt_s = ST_IDLE;
      end
      ST_WAIT_START: begin
        if (start_bit_s) state_nxt_s = ST_RECV;
        else if (tmo_s)  state_nxt_s = ST_DONE;
        else             state_nxt_s = ST_WAIT_START;
      end
      ST_RECV: begin
        if (last_bit_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_RECV;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase

    if (abort_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // FSM state, counter, payload shifter and status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      long_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      resp_r    <= 120'd0;
      tx_err_r  <= 1'b0;
      end_err_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_WAIT_START) || (state_nxt_s == ST_RECV);
      done_r  <= (state_nxt_s == ST_DONE);

      if (accept_s) begin
        cnt_r     <= '0;
        long_r    <= long_i;
        resp_r    <= 120'd0;
        tx_err_r  <= 1'b0;
        end_err_r <= 1'b0;
        timeout_r <= 1'b0;
      end else begin
        if (start_bit_s)      cnt_r <= CNT_ONE;
        else if (wait_strb_s) cnt_r <= cnt_r + CNT_ONE;
        else if (rx_bit_s)    cnt_r <= cnt_r + CNT_ONE;
        else                  cnt_r <= cnt_r;

        // Only header index/argument (short) or R2 body (long) reach resp_o
        if (rx_bit_s && payload_s) resp_r <= {resp_r[118:0], cmd_i};
        else                       resp_r <= resp_r;

        if (rx_bit_s && !long_r && (cnt_r == CNT_ONE)) tx_err_r <= cmd_i;
        else                                           tx_err_r <= tx_err_r;

        if (last_bit_s) end_err_r <= !cmd_i;
        else            end_err_r <= end_err_r;

        if (tmo_s) timeout_r <= 1'b1;
        else       timeout_r <= timeout_r;
      end
    end
  end

`ifdef SD_RESP_CRC_CHK_EN
  localparam logic [CW-1:0] SH_CRC_LO = CW'(FRAME_SHORT - 8);
  localparam logic [CW-1:0] LG_CRC_LO = CW'(FRAME_LONG - 8);

  logic [6:0] crc_s;
  logic [6:0] crc_rx_r;
  logic       crc_err_r;
  logic       crc_en_s;
  logic       crc_field_s;

  // Short CRC spans start bit through argument; long CRC spans the R2 body only
  assign crc_en_s    = (start_bit_s && !long_r) ||
                       (rx_bit_s && (long_r ? payload_s : (cnt_r <= SH_PL_HI)));
  assign crc_field_s = (cnt_r >= (long_r ? LG_CRC_LO : SH_CRC_LO)) &&
                       (cnt_r <= (last_cnt_s - CNT_ONE));

  sd_crc7_sync u_crc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept_s),
    .en_i   (crc_en_s),
    .bit_i  (cmd_i),
    .crc_o  (crc_s)
  );

  // Received CRC field capture and comparison at the end bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_rx_r  <= 7'd0;
      crc_err_r <= 1'b0;
    end else if (accept_s) begin
      crc_rx_r  <= 7'd0;
      crc_err_r <= 1'b0;
    end else begin
      if (rx_bit_s && crc_field_s) crc_rx_r <= {crc_rx_r[5:0], cmd_i};
      else                         crc_rx_r <= crc_rx_r;

      if (last_bit_s) crc_err_r <= (crc_s != crc_rx_r);
      else            crc_err_r <= crc_err_r;
    end
  end

  assign crc_err_o = crc_err_r;
`else
  assign crc_err_o = 1'b0;
`endif

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign resp_o    = resp_r;
  assign end_err_o = end_err_r;
  assign tx_err_o  = tx_err_r;
  assign timeout_o = timeout_r;

endmodule
